line_memory: RTL and testbench

- Backing-store responder on the cache<->memory interface; sits behind the direct-mapped cache.
- Accepts one 128-bit line read or write per request, after a programmable access latency.
- Returns read data and a one-cycle ready pulse.
- Used both as the system main-memory model and as the timing target for cache verification.

---
 rtl/line_memory.sv | 134 +++++++++++++
 tb/tb_line_memory.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/line_memory.sv
// Cache-side backing store: one 128-bit line read or write per request, answered after LATENCY cycles.
// Optional completion counters are built when LINE_MEMORY_STATS_EN is defined.
module line_memory #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         r,
    input  logic         cache2mem_valid,
    input  logic         cache2mem_rw,
    input  logic [31:0]  cache2mem_addr,
    input  logic [127:0] cache2mem_data,
    output logic [127:0] mem2cache_data,
    output logic         mem2cache_ready,
    output logic         mem_busy,
    output logic [31:0]  stat_reads,
    output logic [31:0]  stat_writes,
    output logic [1:0]   dbg_state
);
    localparam int AW = $clog2(DEPTH);

    // Handshake: a request is taken on any rising edge where state is IDLE and
    // cache2mem_valid=1; completion is signalled by a one-cycle mem2cache_ready
    // pulse, during which mem2cache_data carries the read line (0 for writes).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [7:0]     cnt, cnt_nxt;
    logic [AW-1:0]  req_idx;
    logic           req_rw;
    logic [127:0]   req_data;
    logic           accept;
    logic           enter_resp;
    logic [AW-1:0]  cur_idx;
    logic           cur_rw;
    logic [127:0]   cur_data;
    logic [127:0]   mem [DEPTH];
    logic           unused_addr_bits;

    assign unused_addr_bits = ^cache2mem_addr[31:AW];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (cache2mem_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 8'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 8'd1) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 RESP is entered straight from IDLE, before the request
    // registers hold anything, so the commit path takes the live inputs then.
    assign enter_resp = (state_nxt == RESP);
    assign cur_idx    = (state == IDLE) ? cache2mem_addr[AW-1:0] : req_idx;
    assign cur_rw     = (state == IDLE) ? cache2mem_rw : req_rw;
    assign cur_data   = (state == IDLE) ? cache2mem_data : req_data;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            req_idx        <= '0;
            req_rw         <= 1'b0;
            req_data       <= '0;
            mem2cache_data <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                req_idx  <= cache2mem_addr[AW-1:0];
                req_rw   <= cache2mem_rw;
                req_data <= cache2mem_data;
            end
            if (enter_resp && !cur_rw) begin
                mem2cache_data <= mem[cur_idx];
            end else begin
                mem2cache_data <= '0;
            end
        end
    end

    // Array is not reset; a write interrupted by reset never reaches this commit.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_rw) begin
            mem[cur_idx] <= cur_data;
        end
    end

    assign mem2cache_ready = (state == RESP);
    assign mem_busy        = (state != IDLE);
    assign dbg_state       = state;

`ifdef LINE_MEMORY_STATS_EN
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            stat_reads  <= 32'd0;
            stat_writes <= 32'd0;
        end else if (enter_resp) begin
            if (cur_rw) begin
                stat_writes <= stat_writes + 32'd1;
            end else begin
                stat_reads <= stat_reads + 32'd1;
            end
        end
    end
`else
    assign stat_reads  = 32'd0;
    assign stat_writes = 32'd0;
`endif

endmodule

// File: tb/tb_line_memory.sv
// Bench for line_memory: one instance at LATENCY=4, one at LATENCY=1, table vectors plus corner sequences.
module tb_line_memory;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         r;
    logic         v0, rw0, v1, rw1;
    logic [31:0]  a0, a1;
    logic [127:0] d0, d1;
    logic [127:0] q0, q1;
    logic         rdy0, rdy1, busy0, busy1;
    logic [31:0]  sr0, sw0, sr1, sw1;
    logic [1:0]   st0, st1;

    line_memory #(.DEPTH(1024), .LATENCY(4)) dut (
        .clk(clk), .r(r),
        .cache2mem_valid(v0), .cache2mem_rw(rw0), .cache2mem_addr(a0), .cache2mem_data(d0),
        .mem2cache_data(q0), .mem2cache_ready(rdy0), .mem_busy(busy0),
        .stat_reads(sr0), .stat_writes(sw0), .dbg_state(st0)
    );

    line_memory #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .r(r),
        .cache2mem_valid(v1), .cache2mem_rw(rw1), .cache2mem_addr(a1), .cache2mem_data(d1),
        .mem2cache_data(q1), .mem2cache_ready(rdy1), .mem_busy(busy1),
        .stat_reads(sr1), .stat_writes(sw1), .dbg_state(st1)
    );

    typedef struct {
        int           sel;
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    vec_t         vt[8];
    logic [127:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    logic [127:0] l1, rnd, rnd2, rnd3;
    logic [129:0] o;
    int           first_k, second_k;
    logic [127:0] first_d, second_d;
    logic [31:0]  exp_w, exp_r;

    task automatic drive(input int sel, input logic v, input logic rw,
                         input logic [31:0] a, input logic [127:0] d);
        if (sel == 0) begin
            v0 = v; rw0 = rw; a0 = a; d0 = d;
        end else begin
            v1 = v; rw1 = rw; a1 = a; d1 = d;
        end
    endtask

    function automatic logic [129:0] obs(input int sel);
        if (sel == 0) return {rdy0, busy0, q0};
        return {rdy1, busy1, q1};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request: accept, drop valid and scramble inputs, then walk the latency window.
    task automatic do_req(input int sel, input logic rw, input logic [31:0] a,
                          input logic [127:0] d, input logic [127:0] exp);
        int           lat;
        logic [129:0] ob;
        logic [127:0] e;
        lat = (sel == 0) ? 4 : 1;
        @(negedge clk);
        drive(sel, 1'b1, rw, a, d);
        exp_q.push_back(rw ? 128'd0 : exp);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom});
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            ob = obs(sel);
            check("ready", 128'(ob[129]), 128'(k == lat - 1));
            if (k == 0) check("busy", 128'(ob[128]), 128'd1);
            if (k == lat - 1) begin
                e = exp_q.pop_front();
                check("rdata", ob[127:0], e);
            end else begin
                check("data_idle", ob[127:0], 128'd0);
            end
        end
    endtask

    initial begin
        r = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 128'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 128'd0);
        l1   = 128'h0123456789ABCDEF0123456789ABCDEF;
        rnd  = {$urandom, $urandom, $urandom, $urandom};
        rnd2 = {$urandom, $urandom, $urandom, $urandom};
        rnd3 = {$urandom, $urandom, $urandom, $urandom};
        vt[0] = '{0, 1'b1, 32'h0000_0005, l1,     128'd0};
        vt[1] = '{0, 1'b0, 32'h0000_0005, 128'd0, l1};
        vt[2] = '{0, 1'b1, 32'h0000_0020, rnd,    128'd0};
        vt[3] = '{0, 1'b0, 32'h0000_0420, 128'd0, rnd};
        vt[4] = '{1, 1'b1, 32'h0000_0405, rnd2,   128'd0};
        vt[5] = '{1, 1'b0, 32'h0000_0005, 128'd0, rnd2};
        vt[6] = '{1, 1'b1, 32'h0000_03FF, rnd3,   128'd0};
        vt[7] = '{1, 1'b0, 32'hFFFF_FFFF, 128'd0, rnd3};

        // reset, then idle with valid low
        repeat (2) @(posedge clk);
        #1;
        check("reset_dut", 128'(obs(0)), 128'd0);
        check("reset_dut1", 128'(obs(1)), 128'd0);
        @(negedge clk);
        r = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle_dut", 128'(obs(0)), 128'd0);
            check("idle_dut1", 128'(obs(1)), 128'd0);
        end

        for (int i = 0; i < 8; i++) begin
            do_req(vt[i].sel, vt[i].rw, vt[i].addr, vt[i].data, vt[i].exp);
        end

        // write-back then allocate with valid held high across both requests
        do_req(0, 1'b1, 32'd7, {16{8'h55}}, 128'd0);
        first_k = -1;
        second_k = -1;
        first_d = '1;
        second_d = '0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'd3, {16{8'hAA}});
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            o = obs(0);
            if (o[129]) begin
                if (first_k < 0) begin
                    first_k = k;
                    first_d = o[127:0];
                end else if (second_k < 0) begin
                    second_k = k;
                    second_d = o[127:0];
                end
            end
            @(negedge clk);
            if (second_k >= 0) drive(0, 1'b0, 1'b0, 32'd0, 128'd0);
            else if (first_k >= 0) drive(0, 1'b1, 1'b0, 32'd7, 128'd0);
        end
        check("wb_first_at", 128'(first_k), 128'd3);
        check("wb_first_data", first_d, 128'd0);
        check("alloc_second_at", 128'(second_k), 128'd8);
        check("alloc_data", second_d, {16{8'h55}});
        do_req(0, 1'b0, 32'd3, 128'd0, {16{8'hAA}});

        // reset in the middle of a write: no pulse, array untouched
        do_req(0, 1'b1, 32'd9, 128'd0, 128'd0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'd9, {128{1'b1}});
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'd0, 128'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        r = 1'b0;
        #1;
        check("midrst_busy", 128'(busy0), 128'd0);
        check("midrst_ready", 128'(rdy0), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        r = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_ready", 128'(obs(0)), 128'd0);
        end
        do_req(0, 1'b0, 32'd9, 128'd0, 128'd0);

        // completion counters from a clean reset
        @(negedge clk);
        r = 1'b0;
        @(negedge clk);
        r = 1'b1;
        do_req(0, 1'b1, 32'd100, rnd, 128'd0);
        do_req(0, 1'b1, 32'd101, rnd2, 128'd0);
        do_req(0, 1'b0, 32'd100, 128'd0, rnd);
        do_req(0, 1'b1, 32'd102, rnd3, 128'd0);
        do_req(0, 1'b0, 32'd102, 128'd0, rnd3);
`ifdef LINE_MEMORY_STATS_EN
        exp_w = 32'd3;
        exp_r = 32'd2;
`else
        exp_w = 32'd0;
        exp_r = 32'd0;
`endif
        check("stat_writes", 128'(sw0), 128'(exp_w));
        check("stat_reads", 128'(sr0), 128'(exp_r));
        check("stat_dut1_idle", 128'({sw1, sr1}), 128'd0);
        check("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
